// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ valid/ready producers.
// Grants one producer per burst of up to BURST_MAX words and stalls on FIFO almost-full.
module fifo_wr_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 8,
   parameter  int BURST_MAX = 4,
   localparam int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        fifo_full,
   output logic                        fifo_wr_en,
   output logic [DATA_W-1:0]           fifo_data_in,
   output logic [ID_W-1:0]             grant_id,
   output logic                        busy
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   logic [0:0]      state;
   logic [ID_W-1:0] last_id;
   logic [3:0]      burst_cnt;

   logic            sel_found;
   logic [ID_W-1:0] sel_id;
   logic [ID_W-1:0] cand;
   logic            owner_valid;
   logic            accept;
   logic            burst_done;
   logic [DATA_W-1:0] owner_word;

   assign busy        = (state == ST_BURST);
   assign owner_valid = req_valid[grant_id];
   assign owner_word  = req_data[int'(grant_id)*DATA_W +: DATA_W];
   assign accept      = busy && owner_valid && !fifo_full;
   assign burst_done  = (burst_cnt + 4'd1) == 4'(BURST_MAX);

   // Search starts just after the previous owner so every producer gets a turn.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      sel_found = 1'b0;
      sel_id    = '0;
      cand      = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = ID_W'((int'(last_id) + off) % NUM_REQ);
         if (!sel_found && req_valid[cand]) begin
            sel_found = 1'b1;
            sel_id    = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (busy && !fifo_full) req_ready[grant_id] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         grant_id     <= '0;
         last_id      <= ID_W'(NUM_REQ - 1);
         burst_cnt    <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_data_in <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         fifo_wr_en <= accept;
         case (state)
            ST_IDLE: begin
               if (sel_found && !fifo_full) begin
                  grant_id  <= sel_id;
                  burst_cnt <= '0;
                  state     <= ST_BURST;
               end
            end
            default: begin
               if (!owner_valid) begin
                  state   <= ST_IDLE;
                  last_id <= grant_id;
               end else if (!fifo_full) begin
                  fifo_data_in <= owner_word;
                  burst_cnt    <= burst_cnt + 4'd1;
                  if (burst_done) begin
                     state   <= ST_IDLE;
                     last_id <= grant_id;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table for single/back-pressure/full-idle,
// hand sequences for round robin and asynchronous reset mid-burst.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        fifo_full = 1'b0;
   logic        fifo_wr_en;
   logic [7:0]  fifo_data_in;
   logic [1:0]  grant_id;
   logic        busy;

   int total = 0;
   int bad   = 0;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_MAX(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic        full;
      logic [3:0]  ready;
      logic        wr_en;
      logic [7:0]  wdata;
      logic        busy;
      logic [1:0]  grant;
   } vec_t;

   vec_t vecs[22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Owner's slice carries the word; other slices carry distinct filler.
   function automatic logic [31:0] pk(input int owner, input logic [7:0] b);
      logic [31:0] v;
      for (int j = 0; j < 4; j++) v[j*8 +: 8] = (j == owner) ? b : (8'hF0 | 8'(j));
      return v;
   endfunction

   function automatic vec_t mk(input logic [3:0] valid, input logic [31:0] data, input logic full,
                               input logic [3:0] ready, input logic wr_en, input logic [7:0] wdata,
                               input logic bsy, input logic [1:0] grant);
      vec_t v;
      v.valid = valid; v.data = data; v.full = full; v.ready = ready;
      v.wr_en = wr_en; v.wdata = wdata; v.busy = bsy; v.grant = grant;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0; req_data = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int k[4];
      int wcount;
      int cyc_exp;
      logic [7:0] wexp;

      // single producer 2 (last_id starts at 3)
      vecs[0]  = mk(4'b0100, pk(2, 8'hA1), 0, 4'b0000, 0, 8'h00, 0, 2'd0);
      vecs[1]  = mk(4'b0100, pk(2, 8'hA1), 0, 4'b0100, 0, 8'h00, 1, 2'd2);
      vecs[2]  = mk(4'b0100, pk(2, 8'hB2), 0, 4'b0100, 1, 8'hA1, 1, 2'd2);
      vecs[3]  = mk(4'b0100, pk(2, 8'hC3), 0, 4'b0100, 1, 8'hB2, 1, 2'd2);
      vecs[4]  = mk(4'b0000, pk(0, 8'h00), 0, 4'b0100, 1, 8'hC3, 1, 2'd2);
      vecs[5]  = mk(4'b0000, pk(0, 8'h00), 0, 4'b0000, 0, 8'hC3, 0, 2'd2);
      // back-pressure on producer 0 after two accepts
      vecs[6]  = mk(4'b0001, pk(0, 8'h50), 0, 4'b0000, 0, 8'hC3, 0, 2'd0);
      vecs[7]  = mk(4'b0001, pk(0, 8'h50), 0, 4'b0001, 0, 8'hC3, 1, 2'd0);
      vecs[8]  = mk(4'b0001, pk(0, 8'h51), 0, 4'b0001, 1, 8'h50, 1, 2'd0);
      vecs[9]  = mk(4'b0001, pk(0, 8'h52), 1, 4'b0000, 1, 8'h51, 1, 2'd0);
      vecs[10] = mk(4'b0001, pk(0, 8'h52), 1, 4'b0000, 0, 8'h51, 1, 2'd0);
      vecs[11] = mk(4'b0001, pk(0, 8'h52), 1, 4'b0000, 0, 8'h51, 1, 2'd0);
      vecs[12] = mk(4'b0001, pk(0, 8'h52), 0, 4'b0001, 0, 8'h51, 1, 2'd0);
      vecs[13] = mk(4'b0001, pk(0, 8'h53), 0, 4'b0001, 1, 8'h52, 1, 2'd0);
      vecs[14] = mk(4'b0000, pk(0, 8'h00), 0, 4'b0000, 1, 8'h53, 0, 2'd0);
      vecs[15] = mk(4'b0000, pk(0, 8'h00), 0, 4'b0000, 0, 8'h53, 0, 2'd0);
      // full while idle, producer 1
      vecs[16] = mk(4'b0010, pk(1, 8'h77), 1, 4'b0000, 0, 8'h53, 0, 2'd0);
      vecs[17] = mk(4'b0010, pk(1, 8'h77), 1, 4'b0000, 0, 8'h53, 0, 2'd0);
      vecs[18] = mk(4'b0010, pk(1, 8'h77), 0, 4'b0000, 0, 8'h53, 0, 2'd0);
      vecs[19] = mk(4'b0010, pk(1, 8'h77), 0, 4'b0010, 0, 8'h53, 1, 2'd1);
      vecs[20] = mk(4'b0000, pk(0, 8'h00), 0, 4'b0010, 1, 8'h77, 1, 2'd1);
      vecs[21] = mk(4'b0000, pk(0, 8'h00), 0, 4'b0000, 0, 8'h77, 0, 2'd1);

      // reset held with every producer valid
      rst_n = 1'b0; req_valid = 4'hF; req_data = 32'h33221100; fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst ready", 32'(req_ready), 32'h0);
      check("rst wr_en", 32'(fifo_wr_en), 32'h0);
      check("rst data", 32'(fifo_data_in), 32'h0);
      check("rst busy", 32'(busy), 32'h0);
      check("rst grant", 32'(grant_id), 32'h0);
      @(negedge clk);
      req_valid = '0;
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         req_valid = vecs[i].valid; req_data = vecs[i].data; fifo_full = vecs[i].full;
         #1;
         check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].ready));
         check($sformatf("vec%0d wr_en", i), 32'(fifo_wr_en), 32'(vecs[i].wr_en));
         check($sformatf("vec%0d data", i), 32'(fifo_data_in), 32'(vecs[i].wdata));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
         if (vecs[i].busy) check($sformatf("vec%0d grant", i), 32'(grant_id), 32'(vecs[i].grant));
      end

      // round robin: all four producers continuously valid
      do_reset();
      k = '{0, 0, 0, 0};
      wcount = 0;
      for (int cyc = 0; cyc < 26; cyc++) begin
         @(negedge clk);
         req_valid = 4'hF;
         for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(16 * i + k[i]);
         #1;
         if (cyc % 5 == 0) check($sformatf("rr gap busy c%0d", cyc), 32'(busy), 32'h0);
         if (cyc % 5 == 1) begin
            check($sformatf("rr busy c%0d", cyc), 32'(busy), 32'h1);
            check($sformatf("rr grant c%0d", cyc), 32'(grant_id), 32'((cyc / 5) % 4));
         end
         if (fifo_wr_en) begin
            wexp    = 8'(16 * ((wcount / 4) % 4) + (wcount / 16) * 4 + wcount % 4);
            cyc_exp = 5 * (wcount / 4) + 2 + wcount % 4;
            check($sformatf("rr word%0d", wcount), 32'(fifo_data_in), 32'(wexp));
            check($sformatf("rr word%0d cycle", wcount), cyc, cyc_exp);
            wcount++;
         end
         for (int i = 0; i < 4; i++) if (req_ready[i] && req_valid[i]) k[i]++;
      end
      check("rr write count", wcount, 20);

      // asynchronous reset mid-burst from producer 3
      do_reset();
      @(negedge clk);
      req_valid = 4'b1000; req_data = pk(3, 8'h3A);
      @(negedge clk);
      #1;
      check("ar busy", 32'(busy), 32'h1);
      check("ar grant", 32'(grant_id), 32'h3);
      check("ar ready", 32'(req_ready), 32'h8);
      @(negedge clk);
      req_data = pk(3, 8'h3B);
      #1;
      check("ar wr1", 32'(fifo_data_in), 32'h3A);
      @(negedge clk);
      req_valid = 4'b1001; req_data = pk(3, 8'h3C);
      #1;
      check("ar wr2", 32'(fifo_data_in), 32'h3B);
      check("ar wr2 en", 32'(fifo_wr_en), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("ar clr busy", 32'(busy), 32'h0);
      check("ar clr wr_en", 32'(fifo_wr_en), 32'h0);
      check("ar clr data", 32'(fifo_data_in), 32'h0);
      check("ar clr ready", 32'(req_ready), 32'h0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("ar regrant busy", 32'(busy), 32'h1);
      check("ar regrant id", 32'(grant_id), 32'h0);
      check("ar regrant ready", 32'(req_ready), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the 8-bit synchronous FIFO between NUM_REQ producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, stalls on FIFO back-pressure, and drives the FIFO's `wr_en`/`data_in` from registers. It sits directly in front of the FIFO; the FIFO read side is untouched.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_W`, 8: data width; matches the FIFO.
- `BURST_MAX`, 4: maximum words accepted per grant, 1..15.
- `clk`  in  1  rising-edge clock, shared with the FIFO.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  producer i has a word on its slice.
- `req_data`  in  NUM_REQ*DATA_W  producer i data at bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  combinational; word i is accepted on a cycle where valid[i] && ready[i].
- `fifo_full`  in  1  FIFO has ≤1 free entry (almost-full, covering the one in-flight registered write).
- `fifo_wr_en`  out  1  registered write strobe to the FIFO.
- `fifo_data_in`  out  DATA_W  registered write data to the FIFO.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current owner; valid while `busy`=1.
- `busy`  out  1  high in the BURST state.

## Operation
- The FSM has two states: IDLE and BURST.
- Registers: `state`, `grant_id`, `last_id` (round-robin pointer), `burst_cnt` (4 bits), `fifo_wr_en`, `fifo_data_in`.
- IDLE:
  - If any `req_valid` and !`fifo_full`, select the first valid index searching `last_id+1`, `last_id+2`, … with modulo-NUM_REQ wrap.
  - Load `grant_id`, clear `burst_cnt`, and go to BURST.
  - Otherwise stay in IDLE.
  - `req_ready` is all zeros in IDLE.
- BURST: `req_ready[grant_id]` = !`fifo_full`; all other ready bits are 0.
  - Accept (valid && ready): register `fifo_wr_en`=1, `fifo_data_in`=word, and increment `burst_cnt`. When `burst_cnt` reaches BURST_MAX, go to IDLE and set `last_id`=`grant_id`.
  - `req_valid[grant_id]`=0: go to IDLE the same edge with no accept, and set `last_id`=`grant_id`.
  - `fifo_full`=1 with valid=1: stall. Hold the grant; `burst_cnt` is unchanged; stalled cycles do not count toward BURST_MAX.
- `fifo_wr_en` is 0 on every cycle without an accept on the previous edge. `fifo_data_in` holds its last value when no accept occurs.
- Exactly one word is written per accept. No word is duplicated or dropped.
- Reset values: `state`=IDLE, `grant_id`=0, `last_id`=NUM_REQ-1 (so index 0 wins first), `burst_cnt`=0, `fifo_wr_en`=0, `fifo_data_in`=0, `busy`=0, `req_ready`=0.
- Reset mid-burst: all registers return to their reset values immediately and asynchronously. An accept on the edge coinciding with reset assertion is lost.

## Timing
- Arbitration takes 1 cycle. If valid is seen in IDLE on edge N, the grant and `busy` are visible after edge N, the first accept occurs on edge N+1, and `fifo_wr_en` is high after edge N+1.
- Data latency is 1 cycle from accept to the FIFO write strobe.
- Steady state is one word per cycle during a burst.
- Handover costs 1 idle cycle: the BURST→IDLE edge, then IDLE→BURST on the next edge.
- Maximum wait for a continuously valid producer, with FIFO not full: (NUM_REQ-1)·(BURST_MAX+1) cycles.
- `fifo_full` is sampled combinationally into `req_ready`. It must be registered in the FIFO; there is no combinational path from `req_ready` back to `fifo_full`.

## Test plan
- **Reset:** hold `rst_n`=0 with all `req_valid`=1. All outputs at reset values; `req_ready`=0; no `fifo_wr_en`.
- **Single producer:** producer 2 presents 0xA1, 0xB2, 0xC3, then drops valid; BURST_MAX=4. `grant_id`=2 and writes of A1, B2, C3 on 3 consecutive cycles, then IDLE.
- **Round robin:** all 4 producers continuously valid, producer i sends 0x10·i+k. Grant order is 0,1,2,3,0; each burst is exactly 4 words with a 1-cycle gap; FIFO receives 00,01,02,03,10,…
- **Back-pressure:** force `fifo_full`=1 for 3 cycles mid-burst after 2 accepts. `req_ready`=0 and `fifo_wr_en`=0 for those cycles; the grant is held. After release, 2 more words are accepted (total 4), with no loss or duplicate.
- **Full while idle:** `fifo_full`=1 with producer 1 valid. The arbiter stays in IDLE with `busy`=0. When `fifo_full` drops, it grants 1 on the next edge.
- **Async reset mid-burst:** pulse `rst_n` low between edges during a burst from producer 3. Outputs clear immediately. After release, producer 0 wins over a still-valid producer 3.
